ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
//  Parametrised owner arbiter for the shared 64K SRAM. It generalises the fixed three-way
//  loader/CPU/diagnostics mux into one boot loader, one CPU port and NUM_SVC service channels.
//  The loader owns RAM until boot completes. After that the CPU owns RAM.
//  A service channel is granted RAM only after the CPU has been halted via cpu_rdy and a settle time.
//  Sits between spi_flash_reader/diagnostics/ramenable and sram64k.
// PARAMETERS
//  ADDR_W       16  RAM address width
//  DATA_W       8   RAM data width
//  NUM_SVC      2   number of service channels (>=1)
//  HALT_SETTLE  4   clk cycles between cpu_rdy low and service grant (>=1)
//  SVC_TIMEOUT  65535  grant watchdog length in clk cycles (used only with RAMARB_TIMEOUT_EN)
// PORTS
//  clk        in   1                 system clock (SB_HFOSC domain)
//  rst        in   1                 asynchronous, active-high reset
//  boot_done  in   1                 loader finished filling RAM (sticky once seen)
//  ldr_addr/ldr_wdata/ldr_cs/ldr_we     in  ADDR_W/DATA_W/1/1        loader RAM request
//  cpu_addr/cpu_wdata/cpu_cs/cpu_we     in  ADDR_W/DATA_W/1/1        CPU RAM request
//  svc_req    in   NUM_SVC           per-channel ownership request (level)
//  svc_addr/svc_wdata  in  NUM_SVC*ADDR_W / NUM_SVC*DATA_W  flattened; ch i at [i*W +: W]
//  svc_cs/svc_we       in  NUM_SVC / NUM_SVC                    per-channel strobes
//  svc_gnt    out  NUM_SVC           one-hot grant
//  svc_err    out  NUM_SVC           one-cycle timeout pulse (0 when macro off)
//  ram_addr/ram_wdata/ram_cs/ram_we     out ADDR_W/DATA_W/1/1        muxed SRAM request
//  ram_rdata  in   DATA_W            SRAM read data (broadcast to all requesters)
//  cpu_rdata  out  DATA_W            ram_rdata in S_RUN/S_HALT_WAIT, else 0
//  cpu_rdy    out  1                 CPU RDY; high only in S_RUN
//  cpu_dout_en out 1                 = cpu_rdy & cpu_cs & ~cpu_we (data pin output enable)
// BEHAVIOUR
//  Reset (async): state=S_BOOT, svc_gnt=0, svc_err=0, cpu_rdy=0, rr_ptr=0, counters=0.
//  Mux: S_BOOT->loader; S_RUN/S_HALT_WAIT->CPU; S_SVC->svc[sel]; S_RELEASE->ram_cs=0, ram_we=0.
//  Request mux is combinational (0 latency); state/grant/rdy are registered (1 clk).
//  S_BOOT: boot_done=1 -> S_RUN. Later deassertion of boot_done is ignored.
//  S_RUN: if |svc_req, then sel = first requesting ch at or after rr_ptr (wrap mod NUM_SVC).
//    Load settle counter with HALT_SETTLE-1 and go to S_HALT_WAIT; cpu_rdy drops in the same registered edge.
//  S_HALT_WAIT: the CPU keeps the RAM so its in-flight cycle completes. Counter decrements.
//    At 0 -> S_SVC with svc_gnt[sel]=1.
//    If svc_req[sel] drops before grant -> S_RUN (no grant issued).
//  S_SVC: hold while svc_req[sel]=1. On drop -> S_RELEASE, gnt=0, rr_ptr=sel+1 (wrap).
//  S_RELEASE (exactly 1 clk, RAM idle): if any svc_req -> S_SVC with next RR sel.
//    That grant is direct: no settle, cpu_rdy stays 0. Otherwise -> S_RUN.
//  Simultaneous requests: round-robin only, never fixed priority. A new request while in S_SVC
//    waits. svc_cs/svc_we of non-granted channels are ignored.
//  cpu_cs during S_SVC is ignored (the CPU is halted). cpu_dout_en is 0 outside S_RUN.
//  At most one svc_gnt bit is high; it is never high in S_BOOT, S_RUN or S_HALT_WAIT.
//  rst mid-operation: immediate return to S_BOOT. The loader re-owns RAM until boot_done is seen again.
// CONFIGURATION
//  RAMARB_TIMEOUT_EN defined: a counter runs in S_SVC and is cleared on any svc_cs of the owner.
//    Reaching SVC_TIMEOUT forces S_RELEASE, gnt=0, and a 1-clk svc_err[sel] pulse. The channel
//    must drop svc_req and re-request (the same still-high request is not regranted until it drops).
//  Not defined: no watchdog and no counter logic; svc_err tied to 0; a grant is held indefinitely.
// TESTING
//  Reset, boot_done=0: ram_addr follows ldr_addr, cpu_rdy=0. boot_done=1 -> cpu_rdy=1 next clk.
//  S_RUN, svc_req[1]=1, HALT_SETTLE=4: cpu_rdy=0 next clk; svc_gnt=2'b10 exactly 4 clks later.
//    ram_addr then = svc_addr[1].
//  svc_req=2'b11 from S_RUN, rr_ptr=0: ch0 granted; ch0 drops -> 1 idle clk (ram_cs=0).
//    Then ch1 granted with cpu_rdy held 0 throughout.
//  svc_req[0] pulses 2 clks during S_HALT_WAIT: no grant, cpu_rdy returns 1, RAM stays on CPU.
//  rst asserted in S_SVC: svc_gnt=0, cpu_rdy=0, ram follows loader in the same cycle as the async reset.
//  RAMARB_TIMEOUT_EN, SVC_TIMEOUT=8, owner silent: gnt drops after 8 clks, svc_err pulses 1 clk.
//    cpu_rdy returns 1 next clk.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: SRAM owner arbiter between boot loader, CPU and NUM_SVC round-robin service channels.
// Optional grant watchdog enabled by defining RAMARB_TIMEOUT_EN.
module ram_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int NUM_SVC     = 2,
    parameter int HALT_SETTLE = 4,
    parameter int SVC_TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      boot_done_i,
    input  logic [ADDR_W-1:0]         ldr_addr_i,
    input  logic [DATA_W-1:0]         ldr_wdata_i,
    input  logic                      ldr_cs_i,
    input  logic                      ldr_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [DATA_W-1:0]         cpu_wdata_i,
    input  logic                      cpu_cs_i,
    input  logic                      cpu_we_i,
    input  logic [NUM_SVC-1:0]        svc_req_i,
    input  logic [NUM_SVC*ADDR_W-1:0] svc_addr_i,
    input  logic [NUM_SVC*DATA_W-1:0] svc_wdata_i,
    input  logic [NUM_SVC-1:0]        svc_cs_i,
    input  logic [NUM_SVC-1:0]        svc_we_i,
    output logic [NUM_SVC-1:0]        svc_gnt_o,
    output logic [NUM_SVC-1:0]        svc_err_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_wdata_o,
    output logic                      ram_cs_o,
    output logic                      ram_we_o,
    input  logic [DATA_W-1:0]         ram_rdata_i,
    output logic [DATA_W-1:0]         cpu_rdata_o,
    output logic                      cpu_rdy_o,
    output logic                      cpu_dout_en_o
);
    localparam int SEL_W = NUM_SVC > 1 ? $clog2(NUM_SVC) : 1;
    localparam int CNT_W = HALT_SETTLE > 1 ? $clog2(HALT_SETTLE) : 1;

    typedef enum logic [2:0] {S_BOOT, S_RUN, S_HALT_WAIT, S_SVC, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d, rr_q, rr_d, pick, idx, sel_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SVC-1:0] eff_req, sel_oh;
    logic               tmo_hit, cpu_on;

    // First eligible requester at or after rr_q; descending loop lets the nearest one win.
    always_comb begin
        pick = rr_q;
        idx  = '0;
        for (int i = NUM_SVC - 1; i >= 0; i--) begin
            idx = SEL_W'((int'(rr_q) + i) % NUM_SVC);
            if (eff_req[idx]) pick = idx;
        end
    end

    always_comb begin
        sel_oh = '0;
        sel_oh[sel_q] = 1'b1;
    end

    assign sel_inc = (sel_q == SEL_W'(NUM_SVC - 1)) ? '0 : sel_q + 1'b1;

`ifdef RAMARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(SVC_TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [NUM_SVC-1:0] blk_q, blk_d, err_q;
    assign tmo_hit   = (state_q == S_SVC) && !svc_cs_i[sel_q] && (tmo_q == TMO_W'(SVC_TIMEOUT - 1));
    assign tmo_d     = (state_q == S_SVC && !svc_cs_i[sel_q]) ? tmo_q + 1'b1 : '0;
    // A timed-out channel stays masked until it drops its request.
    assign blk_d     = (blk_q | (tmo_hit ? sel_oh : '0)) & svc_req_i;
    assign eff_req   = svc_req_i & ~blk_q;
    assign svc_err_o = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            blk_q <= '0;
            err_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            blk_q <= blk_d;
            err_q <= tmo_hit ? sel_oh : '0;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign eff_req   = svc_req_i;
    assign svc_err_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: if (boot_done_i) state_d = S_RUN;
            S_RUN: if (|eff_req) begin
                state_d = S_HALT_WAIT;
                sel_d   = pick;
                cnt_d   = CNT_W'(HALT_SETTLE - 1);
            end
            S_HALT_WAIT: begin
                if (!svc_req_i[sel_q]) state_d = S_RUN;
                else if (cnt_q == '0) state_d = S_SVC;
                else cnt_d = cnt_q - 1'b1;
            end
            S_SVC: if (!svc_req_i[sel_q] || tmo_hit) begin
                state_d = S_RELEASE;
                rr_d    = sel_inc;
            end
            S_RELEASE: begin
                if (|eff_req) begin
                    state_d = S_SVC;
                    sel_d   = pick;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            sel_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // The CPU keeps the bus during the settle window so its in-flight cycle completes.
    assign cpu_on        = (state_q == S_RUN) || (state_q == S_HALT_WAIT);
    assign cpu_rdy_o     = state_q == S_RUN;
    assign cpu_dout_en_o = cpu_rdy_o & cpu_cs_i & ~cpu_we_i;
    assign cpu_rdata_o   = cpu_on ? ram_rdata_i : '0;
    assign svc_gnt_o     = (state_q == S_SVC) ? sel_oh : '0;
    assign ram_addr_o    = (state_q == S_BOOT) ? ldr_addr_i
                         : (state_q == S_SVC)  ? svc_addr_i[sel_q*ADDR_W +: ADDR_W] : cpu_addr_i;
    assign ram_wdata_o   = (state_q == S_BOOT) ? ldr_wdata_i
                         : (state_q == S_SVC)  ? svc_wdata_i[sel_q*DATA_W +: DATA_W] : cpu_wdata_i;
    assign ram_cs_o      = (state_q == S_BOOT) ? ldr_cs_i
                         : (state_q == S_SVC)  ? svc_cs_i[sel_q] : cpu_on & cpu_cs_i;
    assign ram_we_o      = (state_q == S_BOOT) ? ldr_we_i
                         : (state_q == S_SVC)  ? svc_we_i[sel_q] : cpu_on & cpu_we_i;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: table-driven checks of ram_bus_arbiter ownership, round-robin and reset behaviour.
module tb_ram_bus_arbiter;
`ifdef RAMARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 65535;
`endif
    localparam logic [15:0] LA = 16'h1111, CA = 16'h2222, S0 = 16'h3330, S1 = 16'h4441;

    logic        clk = 1'b0, rst = 1'b1, boot_done = 1'b0;
    logic [15:0] ldr_addr = LA, cpu_addr = CA, ram_addr;
    logic [7:0]  ldr_wdata = 8'hA0, cpu_wdata = 8'hC0, ram_wdata, ram_rdata = 8'h5A, cpu_rdata;
    logic        ldr_cs = 1'b1, ldr_we = 1'b0, cpu_cs = 1'b1, cpu_we = 1'b0;
    logic [1:0]  svc_req = '0, svc_cs = '0, svc_we = '0, svc_gnt, svc_err;
    logic [31:0] svc_addr = {S1, S0};
    logic [15:0] svc_wdata = {8'hB1, 8'hB0};
    logic        ram_cs, ram_we, cpu_rdy, cpu_dout_en;
    int          checks = 0, errors = 0;

    typedef struct packed {
        logic        boot;
        logic [1:0]  req;
        logic        ccs;
        logic        cwe;
        logic [1:0]  scs;
        logic [15:0] addr;
        logic        cs;
        logic        rdy;
        logic [1:0]  gnt;
        logic        den;
    } vec_t;
    vec_t v[$];

    ram_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .NUM_SVC(2), .HALT_SETTLE(4), .SVC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .boot_done_i(boot_done),
        .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata), .ldr_cs_i(ldr_cs), .ldr_we_i(ldr_we),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we),
        .svc_req_i(svc_req), .svc_addr_i(svc_addr), .svc_wdata_i(svc_wdata),
        .svc_cs_i(svc_cs), .svc_we_i(svc_we), .svc_gnt_o(svc_gnt), .svc_err_o(svc_err),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_cs_o(ram_cs), .ram_we_o(ram_we),
        .ram_rdata_i(ram_rdata), .cpu_rdata_o(cpu_rdata), .cpu_rdy_o(cpu_rdy),
        .cpu_dout_en_o(cpu_dout_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input vec_t r);
        for (int i = 0; i < n; i++) v.push_back(r);
    endtask

    initial begin
        // boot, req, cpu_cs, cpu_we, svc_cs | addr, cs, rdy, gnt, dout_en
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, LA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b1});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b0});
        add(4, '{1'b0, 2'b10, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b10, 1'b1, 1'b0, 2'b10, S1, 1'b1, 1'b0, 2'b10, 1'b0});
        add(1, '{1'b0, 2'b10, 1'b1, 1'b0, 2'b01, S1, 1'b0, 1'b0, 2'b10, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b0, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b1});
        add(4, '{1'b0, 2'b11, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b11, 1'b1, 1'b0, 2'b01, S0, 1'b1, 1'b0, 2'b01, 1'b0});
        add(1, '{1'b0, 2'b10, 1'b1, 1'b0, 2'b01, CA, 1'b0, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b10, 1'b1, 1'b0, 2'b10, S1, 1'b1, 1'b0, 2'b10, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b0, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b1});
        add(2, '{1'b0, 2'b01, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(2, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b1});
        add(4, '{1'b0, 2'b01, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, S0, 1'b1, 1'b0, 2'b01, 1'b0});
        add(1, '{1'b0, 2'b11, 1'b1, 1'b0, 2'b01, S0, 1'b1, 1'b0, 2'b01, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b0, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b1, 2'b00, 1'b1});
        add(4, '{1'b0, 2'b11, 1'b1, 1'b0, 2'b00, CA, 1'b1, 1'b0, 2'b00, 1'b0});
        add(1, '{1'b0, 2'b11, 1'b1, 1'b0, 2'b10, S1, 1'b1, 1'b0, 2'b10, 1'b0});

        step();
        step();
        chk("reset_addr", ram_addr, LA);
        chk("reset_rdy_gnt_err", {cpu_rdy, svc_gnt, svc_err}, 5'b0);
        chk("reset_cpu_rdata", cpu_rdata, 8'h00);
        rst = 1'b0;

        foreach (v[k]) begin
            boot_done = v[k].boot;
            svc_req   = v[k].req;
            cpu_cs    = v[k].ccs;
            cpu_we    = v[k].cwe;
            svc_cs    = v[k].scs;
            step();
            chk($sformatf("row%0d", k), {ram_addr, ram_cs, cpu_rdy, svc_gnt, cpu_dout_en},
                {v[k].addr, v[k].cs, v[k].rdy, v[k].gnt, v[k].den});
            chk($sformatf("row%0d_err", k), svc_err, 2'b00);
        end
        chk("svc1_wdata", ram_wdata, 8'hB1);

        rst = 1'b1;
        #1;
        chk("async_rst", {ram_addr, ram_cs, cpu_rdy, svc_gnt}, {LA, 1'b1, 1'b0, 2'b00});
        chk("async_rst_wdata", ram_wdata, 8'hA0);
        #2;
        rst = 1'b0;
        svc_req = 2'b00;
        svc_cs = 2'b00;
        boot_done = 1'b0;
        step();
        step();
        chk("reboot_wait", {ram_addr, cpu_rdy}, {LA, 1'b0});
        boot_done = 1'b1;
        step();
        chk("reboot_run", {ram_addr, cpu_rdy, cpu_rdata}, {CA, 1'b1, 8'h5A});

        svc_req = 2'b01;
        step();
        chk("hold_halt", {cpu_rdy, svc_gnt}, 3'b000);
        for (int i = 0; i < 3; i++) step();
        chk("hold_pre_gnt", svc_gnt, 2'b00);
        step();
        chk("hold_gnt", {svc_gnt, ram_addr}, {2'b01, S0});
`ifdef RAMARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("tmo_hold%0d", i), {svc_gnt, svc_err}, 4'b0100);
        end
        step();
        chk("tmo_fire", {svc_gnt, svc_err, cpu_rdy, ram_cs}, 6'b000100);
        step();
        chk("tmo_after", {svc_gnt, svc_err, cpu_rdy}, 5'b00001);
        step();
        chk("tmo_no_regrant", cpu_rdy, 1'b1);
        svc_req = 2'b00;
        step();
        svc_req = 2'b01;
        step();
        chk("tmo_rerequest", cpu_rdy, 1'b0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("hold_long", {svc_gnt, svc_err, cpu_rdy}, 5'b01000);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
